// File: rtl/lts_peak_detector.sv
// LTS peak detector: finds the first correlator peak above threshold and confirms
// the second LTS repetition SPACING samples later, reporting timing or failure.
module lts_peak_detector #(
    parameter int FBIT    = 7,
    parameter int WIN     = 8,
    parameter int SPACING = 64,
    parameter int TOL     = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [FBIT+4:0]   CR_in,
    input  logic [FBIT+4:0]   thr,
    input  logic              search_en,
    output logic              peak_vld,
    output logic [FBIT+4:0]   peak_val,
    output logic [CNT_W-1:0]  peak_pos,
    output logic              sync_done,
    output logic [CNT_W-1:0]  sync_pos,
    output logic              sync_fail,
    output logic              busy
);
    localparam int DW   = FBIT + 5;
    localparam int WC_W = $clog2(WIN + 1);
    localparam logic [CNT_W-1:0] OFS_LO = CNT_W'(SPACING - TOL);
    localparam logic [CNT_W-1:0] OFS_HI = CNT_W'(SPACING + TOL);

    typedef enum logic [2:0] {IDLE, ARMED, PEAK1, GAP, PEAK2, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] pos, p1, p1_nx, best_pos, best_pos_nx;
    logic [DW-1:0]    thr_l, thr_nx, best_val, best_val_nx;
    logic [WC_W-1:0]  win_cnt, win_cnt_nx;
    logic [CNT_W-1:0] win_lo, win_hi;
    logic             close1, close2, hit2;
    logic             pv_nx, done_nx, fail_nx, busy_nx;

    // Modulo-2^CNT_W window bounds, so counter wrap needs no special case
    assign win_lo = p1 + OFS_LO;
    assign win_hi = p1 + OFS_HI;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pos       <= '0;
            p1        <= '0;
            thr_l     <= '0;
            best_val  <= '0;
            best_pos  <= '0;
            win_cnt   <= '0;
            peak_vld  <= 1'b0;
            peak_val  <= '0;
            peak_pos  <= '0;
            sync_done <= 1'b0;
            sync_pos  <= '0;
            sync_fail <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            if (ena) pos <= pos + CNT_W'(1);
            p1        <= p1_nx;
            thr_l     <= thr_nx;
            best_val  <= best_val_nx;
            best_pos  <= best_pos_nx;
            win_cnt   <= win_cnt_nx;
            peak_vld  <= pv_nx;
            sync_done <= done_nx;
            sync_fail <= fail_nx;
            busy      <= busy_nx;
            if (pv_nx) begin
                peak_val <= best_val_nx;
                peak_pos <= best_pos_nx;
            end
            if (done_nx) sync_pos <= best_pos_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        p1_nx       = p1;
        thr_nx      = thr_l;
        best_val_nx = best_val;
        best_pos_nx = best_pos;
        win_cnt_nx  = win_cnt;
        close1      = 1'b0;
        close2      = 1'b0;
        hit2        = 1'b0;
        if (!search_en) begin
            state_nx = IDLE;
        end else if (ena) begin
            unique case (state)
                IDLE: begin
                    thr_nx   = thr;
                    state_nx = ARMED;
                end
                ARMED: if (CR_in > thr_l) begin
                    best_val_nx = CR_in;
                    best_pos_nx = pos;
                    win_cnt_nx  = '0;
                    state_nx    = PEAK1;
                end
                PEAK1: begin
                    win_cnt_nx = win_cnt + WC_W'(1);
                    if (CR_in > best_val) begin
                        best_val_nx = CR_in;
                        best_pos_nx = pos;
                    end
                    if (win_cnt_nx == WC_W'(WIN)) begin
                        close1   = 1'b1;
                        p1_nx    = best_pos_nx;
                        state_nx = GAP;
                    end
                end
                GAP: if (pos == win_lo) begin
                    best_val_nx = CR_in;
                    best_pos_nx = pos;
                    if (pos == win_hi) close2 = 1'b1;
                    else               state_nx = PEAK2;
                end
                PEAK2: begin
                    if (CR_in > best_val) begin
                        best_val_nx = CR_in;
                        best_pos_nx = pos;
                    end
                    if (pos == win_hi) close2 = 1'b1;
                end
                DONE: ;
                default: state_nx = IDLE;
            endcase
            // Closing sample of a failed confirmation is not re-tested as a crossing
            if (close2) begin
                hit2     = best_val_nx > thr_l;
                state_nx = hit2 ? DONE : ARMED;
            end
        end
    end

    always_comb begin
        pv_nx   = close1 | (close2 & hit2);
        done_nx = close2 & hit2;
        fail_nx = close2 & ~hit2;
        busy_nx = (state_nx == ARMED) || (state_nx == PEAK1) ||
                  (state_nx == GAP)   || (state_nx == PEAK2);
    end
endmodule

// File: tb/tb_lts_peak_detector.sv
// Scoreboard bench for lts_peak_detector: a window-max reference model over the
// recorded sample history predicts pulses; a negedge monitor compares them.
module tb_lts_peak_detector;
    localparam int FBIT = 7, DW = 12, WIN = 8, SPACING = 64, TOL = 1, CNT_W = 16;

    logic clk = 1'b0, rst = 1'b1, ena = 1'b0, search_en = 1'b0;
    logic [DW-1:0] CR_in = '0, thr = '0;
    logic peak_vld, sync_done, sync_fail, busy;
    logic [DW-1:0] peak_val;
    logic [CNT_W-1:0] peak_pos, sync_pos;

    lts_peak_detector #(.FBIT(FBIT), .WIN(WIN), .SPACING(SPACING), .TOL(TOL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ena(ena), .CR_in(CR_in), .thr(thr), .search_en(search_en),
        .peak_vld(peak_vld), .peak_val(peak_val), .peak_pos(peak_pos),
        .sync_done(sync_done), .sync_pos(sync_pos), .sync_fail(sync_fail), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               kind;  // 0 peak1, 1 confirmed peak2, 2 failed confirmation
        logic [DW-1:0]    val;
        logic [CNT_W-1:0] pos;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    // Reference model: searches recorded history for the window maximum
    int               mode = 0;   // 0 idle, 1 armed, 2 peak1 window, 3 await peak2, 4 done
    logic [CNT_W-1:0] mpos = '0, c0 = '0, p1 = '0, bp;
    logic [DW-1:0]    thrl = '0, v;
    logic             exp_busy = 1'b0, m_rst = 1'b1;
    logic [DW-1:0]    hist [0:65535];
    exp_t             ne, me;

    task automatic wmax(input logic [CNT_W-1:0] s, input int n,
                        output logic [DW-1:0] mv, output logic [CNT_W-1:0] mp);
        logic [CNT_W-1:0] k;
        mv = hist[s];
        mp = s;
        for (int i = 1; i < n; i++) begin
            k = s + CNT_W'(i);
            if (hist[k] > mv) begin
                mv = hist[k];
                mp = k;
            end
        end
    endtask

    always @(posedge clk) begin
        m_rst = rst;
        if (rst) begin
            mode = 0; mpos = '0; thrl = '0; exp_busy = 1'b0;
        end else begin
            if (!search_en) mode = 0;
            else if (ena) begin
                hist[mpos] = CR_in;
                case (mode)
                    0: begin thrl = thr; mode = 1; end
                    1: if (CR_in > thrl) begin c0 = mpos; mode = 2; end
                    2: if (mpos == c0 + CNT_W'(WIN)) begin
                        wmax(c0, WIN + 1, v, bp);
                        ne.kind = 0; ne.val = v; ne.pos = bp;
                        q.push_back(ne);
                        p1 = bp;
                        mode = 3;
                    end
                    3: if (mpos == p1 + CNT_W'(SPACING + TOL)) begin
                        wmax(p1 + CNT_W'(SPACING - TOL), 2 * TOL + 1, v, bp);
                        ne.kind = (v > thrl) ? 1 : 2; ne.val = v; ne.pos = bp;
                        q.push_back(ne);
                        mode = (v > thrl) ? 4 : 1;
                    end
                    default: ;
                endcase
            end
            if (ena) mpos = mpos + CNT_W'(1);
            exp_busy = (mode >= 1 && mode <= 3);
        end
    end

    always @(negedge clk) begin
        if (!m_rst) begin
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy actual=%0b required=%0b t=%0t", busy, exp_busy, $time);
            end
            if (peak_vld || sync_done || sync_fail) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse actual vld=%0b done=%0b fail=%0b required none t=%0t",
                             peak_vld, sync_done, sync_fail, $time);
                end else begin
                    me = q.pop_front();
                    if (me.kind == 2) begin
                        if (!(sync_fail && !peak_vld && !sync_done)) begin
                            errors++;
                            $display("FAIL sync_fail_pulse actual vld=%0b done=%0b fail=%0b required fail only",
                                     peak_vld, sync_done, sync_fail);
                        end
                    end else if (!(peak_vld && !sync_fail && sync_done == (me.kind == 1) &&
                                   peak_val == me.val && peak_pos == me.pos &&
                                   (me.kind == 0 || sync_pos == me.pos))) begin
                        errors++;
                        $display("FAIL peak_kind%0d actual vld=%0b done=%0b fail=%0b val=%0d pos=%0d spos=%0d required val=%0d pos=%0d",
                                 me.kind, peak_vld, sync_done, sync_fail, peak_val, peak_pos, sync_pos, me.val, me.pos);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic cyc(input logic e, input logic [DW-1:0] d);
        ena = e;
        CR_in = d;
        @(negedge clk);
    endtask

    int dpos = 0, gaps = 0, abort_at = -1;
    logic [DW-1:0] bg = 50;
    logic [DW-1:0] tbl [int];

    task automatic do_reset();
        rst = 1'b1;
        search_en = 1'b0;
        repeat (3) begin
            cyc(1'($urandom_range(0, 1)), DW'($urandom));
            chk("reset_outputs", {peak_vld, sync_done, sync_fail, busy, peak_val, peak_pos, sync_pos}, 0);
        end
        rst = 1'b0;
        dpos = 0;
    endtask

    task automatic feed(input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            if (gaps != 0) repeat ($urandom_range(0, 2)) cyc(1'b0, DW'($urandom));
            d = tbl.exists(dpos) ? tbl[dpos] : bg;
            if (dpos == abort_at) search_en = 1'b0;
            cyc(1'b1, d);
            dpos++;
        end
    endtask

    task automatic load_s1();
        tbl.delete();
        tbl[10] = 150; tbl[12] = 200; tbl[14] = 120;
        tbl[75] = 90;  tbl[76] = 180; tbl[77] = 110;
    endtask

    initial begin
        @(negedge clk);
        // Full sync, no gaps: exact pulse cycles checked directly
        do_reset(); search_en = 1'b1; thr = 100; load_s1();
        feed(19);
        chk("s1_peak1_vld", peak_vld, 1); chk("s1_peak1_val", peak_val, 200); chk("s1_peak1_pos", peak_pos, 12);
        feed(59);
        chk("s1_sync_done", sync_done, 1); chk("s1_peak2_val", peak_val, 180); chk("s1_sync_pos", sync_pos, 76);
        feed(12);
        chk("s1_done_busy", busy, 0); chk("s1_sync_pos_held", sync_pos, 76);

        // Tie at 12/14 with ena gaps
        do_reset(); search_en = 1'b1; thr = 100; load_s1(); tbl[14] = 200; gaps = 1;
        feed(90);
        chk("s2_sync_pos", sync_pos, 76);
        gaps = 0;

        // Confirmation failure, then a later crossing
        do_reset(); search_en = 1'b1; thr = 100; load_s1();
        tbl[75] = 100; tbl[76] = 60; tbl[77] = 90; tbl[200] = 300;
        feed(78);
        chk("s3_sync_fail", sync_fail, 1); chk("s3_busy", busy, 1);
        feed(123); feed(8);
        chk("s3_repeak_vld", peak_vld, 1); chk("s3_repeak_pos", peak_pos, 200);
        feed(5);

        // Abort in GAP, re-arm with thr=250 latched
        do_reset(); search_en = 1'b1; thr = 100; load_s1();
        feed(40);
        search_en = 1'b0;
        feed(1); chk("s4_abort_busy", busy, 0);
        feed(2);
        thr = 250; search_en = 1'b1; feed(1); thr = 100;
        tbl.delete(); bg = 200; feed(10);
        tbl[dpos] = 300; bg = 50; feed(1 + WIN);
        chk("s4_latched_thr_peak", peak_pos, dpos - 1 - WIN);
        feed(4);

        // Abort on the same sample that closes the peak-1 window
        do_reset(); search_en = 1'b1; thr = 100; load_s1(); abort_at = 18;
        feed(25); abort_at = -1;
        chk("s5_abort_no_pulse", peak_vld, 0);

        // Randomized runs with threshold changes, search_en drops and a mid-run reset
        tbl.delete();
        for (int r = 0; r < 6; r++) begin
            do_reset();
            gaps = $urandom_range(0, 1);
            thr = DW'($urandom_range(100, 600));
            for (int i = 0; i < 300; i++) begin
                if (r == 3 && i == 150) do_reset();
                search_en = ($urandom_range(0, 119) != 0);
                if ($urandom_range(0, 49) == 0) thr = DW'($urandom_range(100, 600));
                if (gaps != 0) repeat ($urandom_range(0, 2)) cyc(1'b0, DW'($urandom));
                cyc(1'b1, ($urandom_range(0, 9) == 0) ? DW'($urandom) : DW'($urandom_range(0, thr)));
            end
        end

        search_en = 1'b0;
        repeat (3) cyc(1'b0, '0);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lts_peak_detector.md
Name: lts_peak_detector

Overview:
- Sits directly downstream of the multiplierless long-training-symbol correlator in the 802.11 OFDM RX chain. Consumes the correlator's unsigned R metric (format 5.FBIT).
- Finds the first metric peak above a threshold, then confirms a second peak SPACING samples later (the two LTS repetitions).
- Reports fine symbol timing (sync_done, sync_pos) or a failed confirmation (sync_fail) to the RX timing/FFT-window control.

Parameters:
- FBIT, 7: fractional bits of the R metric; data width is 5+FBIT.
- WIN, 8: samples examined after the first threshold crossing to locate peak 1. Constraint: WIN < SPACING-TOL.
- SPACING, 64: expected sample distance between peak 1 and peak 2.
- TOL, 1: half-width of the peak-2 search window, in samples.
- CNT_W, 16: width of the sample position counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- ena  in  1  CR_in valid this cycle (one metric sample)
- CR_in  in  5+FBIT  R metric, unsigned 5.FBIT
- thr  in  5+FBIT  detection threshold, same format; latched on IDLE->ARMED
- search_en  in  1  level; enables detection, low forces IDLE
- peak_vld  out  1  one-cycle pulse, peak_val/peak_pos valid
- peak_val  out  5+FBIT  metric value of the reported peak
- peak_pos  out  CNT_W  sample position of the reported peak
- sync_done  out  1  one-cycle pulse, second peak confirmed
- sync_pos  out  CNT_W  position of the confirmed second peak; held until next sync_done
- sync_fail  out  1  one-cycle pulse, second peak not found
- busy  out  1  high in ARMED/PEAK1/GAP/PEAK2

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all outputs 0, FSM=IDLE, sample counter=0, internal best value/position=0, latched threshold=0.
- Sample counter: increments on every ena cycle, in all states, including IDLE. It wraps modulo 2^CNT_W. The position of a sample is the counter value in the cycle the sample is accepted; the first sample after reset is position 0. All position arithmetic is modulo 2^CNT_W.
- ena low: FSM state, window counters and best trackers freeze. No output pulse is generated.
- Comparisons are unsigned and strict (>). On ties the earliest sample wins.
- Output timing: all outputs are registered. A pulse is asserted in the clock after the ena cycle of the sample that closes a window.
- FSM:
  - IDLE: busy=0. If search_en=1, latch thr and go to ARMED.
  - ARMED: on a sample with CR_in > thr_latched: best_val=CR_in, best_pos=pos, win_cnt=0, go to PEAK1.
  - PEAK1: each subsequent sample increments win_cnt and updates best if CR_in > best_val. When the WIN-th sample after the crossing is processed, pulse peak_vld with best_val/best_pos. Store p1=best_pos, go to GAP.
  - GAP: wait until a sample has pos == p1+SPACING-TOL. That sample starts PEAK2: best_val=CR_in, best_pos=pos.
  - PEAK2: track the maximum over positions p1+SPACING-TOL .. p1+SPACING+TOL inclusive. The sample at p1+SPACING+TOL closes the window.
    - If best_val > thr_latched: pulse peak_vld (peak 2) and sync_done in the same cycle, load sync_pos=best_pos, go to DONE.
    - Otherwise: pulse sync_fail, go to ARMED. The closing sample is not itself re-evaluated as a crossing.
  - DONE: busy=0. Stay until search_en=0.
- search_en=0 in any state: go to IDLE in the next cycle with no pulse. This abandons any window in progress.
- Simultaneous search_en fall with a window-closing sample: the abort wins and no pulse is issued.
- rst mid-operation: immediate return to reset values, including sync_pos.
- Counter wrap during GAP/PEAK2 is handled by the modulo compare.

Test Plan:
- Reset: assert rst 3 cycles during random ena/CR_in -> all outputs 0, busy=0. After release, the first ena sample is position 0.
- Peak 1 (thr=100, search_en=1): CR_in=50 everywhere except pos10=150, pos12=200, pos14=120 -> peak_vld one cycle after pos18 sample, peak_val=200, peak_pos=12.
- Full sync: as above plus pos75=90, pos76=180, pos77=110 -> after the pos77 sample, peak_vld with val=180 pos=76, and sync_done with sync_pos=76. Then DONE, busy=0.
- Tie and ena gaps: pos12=200 and pos14=200, random ena-low cycles inserted -> peak_pos=12. Positions and results identical to the gap-free run.
- Confirmation failure: peak 1 at 12, samples at pos75..77 all ≤100 -> sync_fail after the pos77 sample, busy stays 1. A later crossing at pos200=300 -> peak_vld with pos=200.
- Abort: drop search_en during GAP -> no further pulses, busy=0 next cycle. Re-raise with a new thr=250 -> the latched threshold is 250.
